// File: rtl/audio_output_stage.sv
// audio_output_stage: per-channel volume scaling with a soft gain ramp, first-order
// error-feedback requantiser and PWM generation, all in the clk_i domain.
module audio_output_stage #(
    parameter int unsigned      CHANNELS  = 2,
    parameter int unsigned      AUDIO_W   = 16,
    parameter int unsigned      VOL_W     = 16,
    parameter int unsigned      PWM_W     = 7,
    parameter logic [VOL_W-1:0] RAMP_STEP = 'h0100
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        sample_ena_i,
    input  logic                        frame_ena_i,
    input  logic                        active_i,
    input  logic                        mute_i,
    input  logic [CHANNELS*AUDIO_W-1:0] audio_i,
    input  logic [CHANNELS*VOL_W-1:0]   volume_i,
    output logic [CHANNELS-1:0]         pwm_o,
    output logic                        ramping_o
);
    localparam int unsigned PROD_W = AUDIO_W + VOL_W + 1;
    localparam int unsigned ERR_W  = AUDIO_W - PWM_W;

    logic [VOL_W-1:0]         gain_q   [CHANNELS];
    logic [VOL_W-1:0]         gain_d   [CHANNELS];
    logic [VOL_W-1:0]         target   [CHANNELS];
    logic [AUDIO_W-1:0]       audio_q  [CHANNELS];
    logic [AUDIO_W-1:0]       audio_d  [CHANNELS];
    logic signed [PROD_W-1:0] prod_q   [CHANNELS];
    logic signed [PROD_W-1:0] prod_d   [CHANNELS];
    logic [AUDIO_W-1:0]       scaled_q [CHANNELS];
    logic [AUDIO_W-1:0]       scaled_d [CHANNELS];
    logic [ERR_W-1:0]         err_q    [CHANNELS];
    logic [ERR_W-1:0]         err_d    [CHANNELS];
    logic [PWM_W-1:0]         duty_q   [CHANNELS];
    logic [PWM_W-1:0]         duty_d   [CHANNELS];
    logic [AUDIO_W:0]         acc      [CHANNELS];
    logic [PWM_W-1:0]         cnt_q;
    logic [PWM_W-1:0]         cnt_d;
    logic [CHANNELS-1:0]      pwm_q;
    logic [CHANNELS-1:0]      pwm_d;
    logic                     smp1_q;
    logic                     smp2_q;
    logic                     ramp_any;

    // Gain moves toward its target by at most RAMP_STEP per sample and lands exactly on it.
    always_comb begin
        ramp_any = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            target[ch] = (mute_i | ~active_i) ? '0 : volume_i[ch*VOL_W +: VOL_W];
            gain_d[ch] = gain_q[ch];
            if (sample_ena_i) begin
                if (gain_q[ch] < target[ch]) begin
                    if ((target[ch] - gain_q[ch]) > RAMP_STEP) begin
                        gain_d[ch] = gain_q[ch] + RAMP_STEP;
                    end else begin
                        gain_d[ch] = target[ch];
                    end
                end else if (gain_q[ch] > target[ch]) begin
                    if ((gain_q[ch] - target[ch]) > RAMP_STEP) begin
                        gain_d[ch] = gain_q[ch] - RAMP_STEP;
                    end else begin
                        gain_d[ch] = target[ch];
                    end
                end
            end
            if (gain_q[ch] != target[ch]) begin
                ramp_any = 1'b1;
            end
        end
    end

    assign ramping_o = ramp_any;

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            audio_d[ch] = sample_ena_i ? audio_i[ch*AUDIO_W +: AUDIO_W] : audio_q[ch];
            if (smp1_q) begin
                prod_d[ch] = PROD_W'($signed(audio_q[ch])) * $signed(PROD_W'({1'b0, gain_q[ch]}));
            end else begin
                prod_d[ch] = prod_q[ch];
            end
            // Bit-selecting above VOL_W is the floor shift, truncated back to AUDIO_W.
            scaled_d[ch] = smp2_q ? prod_q[ch][VOL_W +: AUDIO_W] : scaled_q[ch];
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc[ch] = {1'b0, ~scaled_q[ch][AUDIO_W-1], scaled_q[ch][AUDIO_W-2:0]}
                    + {{(PWM_W+1){1'b0}}, err_q[ch]};
            duty_d[ch] = duty_q[ch];
            err_d[ch]  = err_q[ch];
            if (frame_ena_i) begin
                if (acc[ch][AUDIO_W]) begin
                    duty_d[ch] = '1;
                    err_d[ch]  = '0;
                end else begin
                    duty_d[ch] = acc[ch][AUDIO_W-1 -: PWM_W];
                    err_d[ch]  = acc[ch][ERR_W-1:0];
                end
            end
            pwm_d[ch] = active_i & (duty_q[ch] > cnt_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (frame_ena_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                gain_q[ch]   <= '0;
                audio_q[ch]  <= '0;
                prod_q[ch]   <= '0;
                scaled_q[ch] <= '0;
                err_q[ch]    <= '0;
                duty_q[ch]   <= '0;
            end
            cnt_q  <= '0;
            pwm_q  <= '0;
            smp1_q <= 1'b0;
            smp2_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                gain_q[ch]   <= gain_d[ch];
                audio_q[ch]  <= audio_d[ch];
                prod_q[ch]   <= prod_d[ch];
                scaled_q[ch] <= scaled_d[ch];
                err_q[ch]    <= err_d[ch];
                duty_q[ch]   <= duty_d[ch];
            end
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
            smp1_q <= sample_ena_i;
            smp2_q <= smp1_q;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: tb/tb_audio_output_stage.sv
// Bench for audio_output_stage: directed scenarios plus randomized stimulus compared
// cycle by cycle against an arithmetic reference model of gain, scaling and duty.
module tb_audio_output_stage;
    localparam int CH           = 2;
    localparam int AW           = 16;
    localparam int VW           = 16;
    localparam int PW           = 7;
    localparam int STEP         = 256;
    localparam int FRAME_PERIOD = 130;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            sampleEna = 1'b0;
    logic            frameEna = 1'b0;
    logic            active = 1'b0;
    logic            mute = 1'b0;
    logic [CH*AW-1:0] audio = '0;
    logic [CH*VW-1:0] volume = '0;
    logic [CH-1:0]   pwm;
    logic            ramping;

    int testsRun = 0;
    int testsFailed = 0;

    int mGain [CH];
    int mScaled [CH];
    int mErr [CH];
    int mDuty [CH];
    int mPwm [CH];
    int pendVal [CH];
    int pendCnt;
    int mCnt;
    int hiCnt [CH];
    int lastHi [CH];
    int hist0 [$];
    int hist1 [$];
    int samplePeriod = 5;
    int sampleCtr = 0;
    int frameCtr = 0;
    bit sampledNow;

    audio_output_stage #(
        .CHANNELS (CH),
        .AUDIO_W  (AW),
        .VOL_W    (VW),
        .PWM_W    (PW),
        .RAMP_STEP(16'h0100)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .sample_ena_i(sampleEna),
        .frame_ena_i (frameEna),
        .active_i    (active),
        .mute_i      (mute),
        .audio_i     (audio),
        .volume_i    (volume),
        .pwm_o       (pwm),
        .ramping_o   (ramping)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    function automatic int targetOf(input int ch);
        if (mute || !active) return 0;
        return int'(volume[ch*VW +: VW]);
    endfunction

    function automatic bit expRamping();
        for (int ch = 0; ch < CH; ch++) begin
            if (mGain[ch] != targetOf(ch)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int ch = 0; ch < CH; ch++) begin
            mGain[ch] = 0;
            mScaled[ch] = 0;
            mErr[ch] = 0;
            mDuty[ch] = 0;
            mPwm[ch] = 0;
            pendVal[ch] = 0;
        end
        pendCnt = 0;
        mCnt = 0;
    endtask

    // One clock edge of the reference behaviour, evaluated from pre-edge inputs and state.
    task automatic modelEdge();
        int acc;
        int t;
        int a;
        longint p;
        for (int ch = 0; ch < CH; ch++) begin
            mPwm[ch] = (active && (mDuty[ch] > mCnt)) ? 1 : 0;
        end
        if (frameEna) begin
            for (int ch = 0; ch < CH; ch++) begin
                acc = mScaled[ch] + 32768 + mErr[ch];
                if (acc >= 65536) begin
                    mDuty[ch] = 127;
                    mErr[ch] = 0;
                end else begin
                    mDuty[ch] = acc / 512;
                    mErr[ch] = acc % 512;
                end
            end
        end
        mCnt = frameEna ? 0 : ((mCnt < 127) ? mCnt + 1 : 127);
        if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) begin
                for (int ch = 0; ch < CH; ch++) mScaled[ch] = pendVal[ch];
            end
        end
        if (sampleEna) begin
            for (int ch = 0; ch < CH; ch++) begin
                t = targetOf(ch);
                if (mGain[ch] < t) mGain[ch] = (mGain[ch] + STEP < t) ? mGain[ch] + STEP : t;
                else if (mGain[ch] > t) mGain[ch] = (mGain[ch] - STEP > t) ? mGain[ch] - STEP : t;
                a = $signed(audio[ch*AW +: AW]);
                p = longint'(a) * longint'(mGain[ch]);
                pendVal[ch] = int'(p >>> 16);
            end
            pendCnt = 2;
        end
    endtask

    task automatic applyStimulus();
        logic [CH-1:0] expPwm;
        frameEna = (frameCtr == 0);
        sampleEna = (sampleCtr == 0);
        @(posedge clk);
        if (!rstN) modelReset();
        else modelEdge();
        sampledNow = sampleEna;
        frameCtr = (frameCtr + 1) % FRAME_PERIOD;
        sampleCtr = (sampleCtr + 1) % samplePeriod;
        #1;
        for (int ch = 0; ch < CH; ch++) expPwm[ch] = mPwm[ch][0];
        checkOutput("pwm", pwm, expPwm);
        checkOutput("ramping", ramping, expRamping());
        if (frameEna) begin
            for (int ch = 0; ch < CH; ch++) begin
                lastHi[ch] = hiCnt[ch];
                hiCnt[ch] = 0;
            end
            hist0.push_back(lastHi[0]);
            hist1.push_back(lastHi[1]);
        end
        for (int ch = 0; ch < CH; ch++) hiCnt[ch] += int'(pwm[ch]);
        frameEna = 1'b0;
        sampleEna = 1'b0;
    endtask

    task automatic runFrames(input int n);
        repeat (n * FRAME_PERIOD) applyStimulus();
    endtask

    task automatic runRamp(output int n);
        n = 0;
        for (int c = 0; c < 20000; c++) begin
            applyStimulus();
            if (sampledNow) n++;
            if (!ramping) break;
        end
    endtask

    task automatic runSamples(input int k);
        int n = 0;
        for (int c = 0; c < 20000 && n < k; c++) begin
            applyStimulus();
            if (sampledNow) n++;
        end
        checkOutput("sampleBudget", n, k);
    endtask

    task automatic pulseReset();
        #2 rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("rstPwm", pwm, 0);
        checkOutput("rstRamping", ramping, expRamping());
        #3 rstN = 1'b1;
    endtask

    initial begin
        int n;
        int first;
        int sum;
        bit found;
        modelReset();
        for (int ch = 0; ch < CH; ch++) begin
            hiCnt[ch] = 0;
            lastHi[ch] = 0;
        end

        // Reset held while the strobes keep toggling.
        repeat (12) applyStimulus();
        checkOutput("resetPwm", pwm, 0);
        checkOutput("resetRamping", ramping, 0);

        rstN = 1'b1;
        active = 1'b1;
        volume = {16'hFFFF, 16'hFFFF};
        samplePeriod = 20;
        sampleCtr = 1;
        runRamp(n);
        checkOutput("rampUpSamples", n, 256);

        runFrames(3);
        checkOutput("dcMidCh0", lastHi[0], 64);
        checkOutput("dcMidCh1", lastHi[1], 64);

        hist0.delete();
        hist1.delete();
        audio = {16'hC000, 16'h4000};
        runFrames(70);
        first = -1;
        foreach (hist0[i]) if (first < 0 && hist0[i] != 64) first = i;
        found = (first >= 0) && (first + 64 <= hist0.size());
        checkOutput("ditherFound", found, 1);
        if (found) begin
            checkOutput("ditherFirst", hist0[first], 95);
            checkOutput("ditherSecond", hist0[first+1], 96);
            checkOutput("negQuarterCh1", hist1[first], 32);
            sum = 0;
            for (int k = 0; k < 64; k++) sum += hist0[first+k];
            checkOutput("ditherSum64", sum, 95 + 63 * 96);
        end

        mute = 1'b1;
        runRamp(n);
        checkOutput("muteSamples", n, 256);
        runFrames(3);
        checkOutput("mutedCh0", lastHi[0], 64);
        checkOutput("mutedCh1", lastHi[1], 64);

        mute = 1'b0;
        runRamp(n);
        checkOutput("unmuteSamples", n, 256);
        audio = {16'h8000, 16'h7FFF};
        runFrames(4);
        checkOutput("satHighCh0", lastHi[0], 127);
        checkOutput("satLowCh1", lastHi[1], 0);

        for (int c = 0; c < FRAME_PERIOD && frameCtr != 10; c++) applyStimulus();
        checkOutput("pwmHighBeforeGate", pwm[0], 1);
        active = 1'b0;
        applyStimulus();
        checkOutput("activeGate", pwm, 0);
        active = 1'b1;
        runFrames(2);

        pulseReset();
        runSamples(128);
        pulseReset();
        runRamp(n);
        checkOutput("rampAfterReset", n, 256);

        // Randomized operation against the reference model.
        for (int seg = 0; seg < 100; seg++) begin
            audio = {16'($urandom), 16'($urandom)};
            if ($urandom_range(3) == 0) volume = {16'($urandom), 16'($urandom)};
            mute = ($urandom_range(3) == 0);
            active = ($urandom_range(4) != 0);
            if ($urandom_range(3) == 0) begin
                samplePeriod = $urandom_range(40, 5);
                sampleCtr = 1;
            end
            if (seg == 50) pulseReset();
            repeat ($urandom_range(300, 100)) applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
